blink_event_scheduler: RTL
==========================

Name: blink_event_scheduler

Overview:
- Central accounting controller for the LED blinker farm.
- Up to three blinker instances raise 1-cycle blink-event pulses; this block queues them per source and arbitrates round-robin onto a single shared total counter (one increment per cycle, so simultaneous events are never lost).
- Gates the blinkers via run enables, stops them at a programmable limit or on request, and presents the final count to the 7-segment decoder.

Parameters:
- LIMIT, 15, total count at which all blinkers are stopped (1..2^CNT_W-1).
- CNT_W, 4, width of total counter.
- PEND_W, 2, width of each per-source pending counter (saturating).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  level/pulse; in IDLE or DONE begins a new run.
- stop  in  1  request early stop; sampled only in RUN.
- evt  in  3  blink-event pulses, bit i from blinker i; 1 cycle each.
- run_en  out  3  enable to blinkers; all-ones in RUN, else 0.
- grant  out  3  one-hot, registered; pulses the cycle after source i is counted.
- total  out  CNT_W  shared event count, to 7-segment decoder.
- done  out  1  high in DONE.
- busy  out  1  high in RUN or DRAIN.
- drop  out  1  sticky; set when an event arrives at a saturated pending counter.

Behaviour:
- Reset (reset=0, async): state=IDLE, total=0, pending[0..2]=0, rr pointer=0 (source 0 highest priority), run_en=0, grant=0, done=0, busy=0, drop=0. All outputs registered.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: evt ignored, total held. start=1 -> RUN; on that edge total, pending, drop cleared.
- RUN:
  - run_en=3'b111.
  - Each edge, evt[i]=1 increments pending[i].
  - Arbiter picks one source with pending>0, searching from rr pointer upward modulo 3. The chosen pending decrements, total+1, grant[chosen]=1 for the next cycle, and pointer = chosen+1 mod 3. No pending -> grant=0, pointer held.
  - Same-edge evt[i] and grant of i: pending[i] unchanged.
  - Pending at max (2^PEND_W-1) with evt[i]=1 and no grant to i: value held, drop=1.
- RUN exits:
  - Increment making total==LIMIT -> DONE on that edge.
  - Else stop=1 -> DRAIN. Limit has priority over stop on the same edge.
- DRAIN: run_en=0, new evt ignored; keep granting pending, one per cycle. Exit to DONE when total reaches LIMIT or all pending==0 (checked after the edge's update).
- DONE: run_en=0, done=1, total frozen, evt ignored, leftover pending cleared. start=1 -> RUN with clear as from IDLE.
- Latency: evt sampled at edge E0 with pending empty and source top priority -> total updated and grant high after E1 (2-edge latency). Worst case with all three pending is +2 cycles.
- total never exceeds LIMIT; no wrap.
- start while busy ignored.
- Reset mid-run aborts immediately to IDLE values.

Test Plan:
- Reset, start, single evt=3'b001 at E0 -> after E1 total=1, grant=3'b001 one cycle, run_en=3'b111, busy=1.
- All three evt same cycle, pointer=0 -> grants 001,010,100 on consecutive cycles, total 0->3, pointer back to 0; then evt=3'b101 -> grants 001 then 100.
- Continuous evt=3'b111 every cycle, LIMIT=15 -> total climbs to 15, state DONE, run_en=0, done=1, total held at 15; later events do not change total.
- Source 2 pulsed 5 times in consecutive cycles while sources 0/1 saturate the arbiter -> pending[2] saturates at 3, drop=1 stays set until next start.
- Total=6 with pending={1,1,0}, assert stop -> DRAIN, run_en=0, two further grants, total=8, DONE, done=1; evt during DRAIN ignored.
- Mid-run with total=9, assert reset=0 asynchronously between edges -> outputs immediately at reset values (total=0, run_en=0); after release and start, counting resumes from 0 with source 0 priority.

Source files
------------

// File: rtl/blink_event_scheduler_if.sv
// blink_event_scheduler_if: control, event and status bundle between the scheduler and the blinker farm
interface blink_event_scheduler_if #(parameter int CNT_W = 4);
  logic start, stop;
  logic [2:0] evt, run_en, grant;
  logic [CNT_W-1:0] total;
  logic done, busy, drop;
  modport master (output start, stop, evt, input run_en, grant, total, done, busy, drop);
  modport slave (input start, stop, evt, output run_en, grant, total, done, busy, drop);
endinterface

// File: rtl/blink_event_scheduler.sv
// blink_event_scheduler: queues blink events per source and counts them round-robin into one shared total
module blink_event_scheduler #(
  parameter int LIMIT = 15,
  parameter int CNT_W = 4,
  parameter int PEND_W = 2
) (
  input logic clk,
  input logic reset,
  blink_event_scheduler_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2, S_DONE = 2'd3;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] C1 = CNT_W'(1);
  localparam logic [PEND_W-1:0] PMAX = '1;
  localparam logic [PEND_W-1:0] P1 = PEND_W'(1);
  logic [1:0] state_q, state_d, ptr_q, ptr_d, p1, p2, sel;
  logic [CNT_W-1:0] total_q, total_d;
  logic [PEND_W-1:0] pend_q [3];
  logic [PEND_W-1:0] pend_d [3];
  logic [2:0] grant_q, grant_d, run_en_q, has;
  logic drop_q, drop_d, done_q, busy_q, active, clr;
  assign has = {pend_q[2] != '0, pend_q[1] != '0, pend_q[0] != '0};
  assign p1 = ptr_q == 2'd2 ? 2'd0 : ptr_q + 2'd1;
  assign p2 = p1 == 2'd2 ? 2'd0 : p1 + 2'd1;
  // search order is ptr, ptr+1, ptr+2 (mod 3); sel is only used when some source has pending
  assign sel = has[ptr_q] ? ptr_q : has[p1] ? p1 : p2;
  assign active = state_q == S_RUN || state_q == S_DRAIN;
  assign clr = (state_q == S_IDLE || state_q == S_DONE) && bus.start;
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    pend_d = pend_q;
    ptr_d = ptr_q;
    drop_d = drop_q;
    grant_d = '0;
    if (active && has != '0) begin
      pend_d[sel] = pend_q[sel] - P1;
      total_d = total_q + C1;
      grant_d[sel] = 1'b1;
      ptr_d = sel == 2'd2 ? 2'd0 : sel + 2'd1;
    end
    // an event on the source being granted this edge cancels out, so its pending is left as it was
    if (state_q == S_RUN)
      for (int i = 0; i < 3; i++)
        if (bus.evt[i]) begin
          if (grant_d[i]) pend_d[i] = pend_q[i];
          else if (pend_q[i] == PMAX) drop_d = 1'b1;
          else pend_d[i] = pend_q[i] + P1;
        end
    if (state_q == S_DONE) pend_d = '{default: '0};
    if (clr) begin
      state_d = S_RUN;
      total_d = '0;
      pend_d = '{default: '0};
      drop_d = 1'b0;
    end else if (state_q == S_RUN)
      state_d = total_d == LIM ? S_DONE : bus.stop ? S_DRAIN : S_RUN;
    else if (state_q == S_DRAIN && (total_d == LIM || {pend_d[2], pend_d[1], pend_d[0]} == '0))
      state_d = S_DONE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= S_IDLE;
      total_q <= '0;
      pend_q <= '{default: '0};
      ptr_q <= 2'd0;
      grant_q <= '0;
      drop_q <= 1'b0;
      run_en_q <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      pend_q <= pend_d;
      ptr_q <= ptr_d;
      grant_q <= grant_d;
      drop_q <= drop_d;
      run_en_q <= {3{state_d == S_RUN}};
      done_q <= state_d == S_DONE;
      busy_q <= state_d == S_RUN || state_d == S_DRAIN;
    end
  assign bus.run_en = run_en_q;
  assign bus.grant = grant_q;
  assign bus.total = total_q;
  assign bus.done = done_q;
  assign bus.busy = busy_q;
  assign bus.drop = drop_q;
endmodule
